// File: rtl/pcode_corr.sv
// pcode_corr: early/prompt/late P-code despreader with integrate-and-dump, valid/ready output and lock FSM.
module pcode_corr #(
  parameter int INT_LEN   = 1023,
  parameter int ACC_WIDTH = 16,
  parameter int LOCK_THR  = 512,
  parameter int LOCK_CNT  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        rx_chip,
  input  logic                        loc_chip,
  output logic signed [ACC_WIDTH-1:0] acc_e,
  output logic signed [ACC_WIDTH-1:0] acc_p,
  output logic signed [ACC_WIDTH-1:0] acc_l,
  output logic                        acc_valid,
  input  logic                        acc_ready,
  output logic                        overrun,
  output logic                        slip,
  output logic                        lock
);
  localparam int CW = $clog2(INT_LEN);
  localparam int HW = $clog2(LOCK_CNT + 1);
  typedef logic signed [ACC_WIDTH-1:0] acc_t;
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCK} state_t;
  logic [1:0] dly_q, dly_d;
  logic [CW-1:0] cnt_q, cnt_d;
  acc_t ae_q, ae_d, ap_q, ap_d, al_q, al_d;
  acc_t oe_q, oe_d, op_q, op_d, ol_q, ol_d;
  acc_t se, sp, sl, mag;
  logic valid_q, valid_d, overrun_q, overrun_d, slip_q, slip_d, lock_q, lock_d;
  logic dump, hit;
  state_t state_q, state_d;
  logic [HW-1:0] hits_q, hits_d, miss_q, miss_d, hits_n, miss_n;
  assign acc_e = oe_q;
  assign acc_p = op_q;
  assign acc_l = ol_q;
  assign acc_valid = valid_q;
  assign overrun = overrun_q;
  assign slip = slip_q;
  assign lock = lock_q;
  always_comb begin
    dump = en && cnt_q == CW'(INT_LEN - 1);
    se = ae_q + (rx_chip == loc_chip ? acc_t'(1) : acc_t'(-1));
    sp = ap_q + (rx_chip == dly_q[0] ? acc_t'(1) : acc_t'(-1));
    sl = al_q + (rx_chip == dly_q[1] ? acc_t'(1) : acc_t'(-1));
    mag = sp[ACC_WIDTH-1] ? -sp : sp;
    hit = mag >= acc_t'(LOCK_THR);
    dly_d = en ? {dly_q[0], loc_chip} : dly_q;
    cnt_d = !en ? cnt_q : dump ? '0 : cnt_q + 1'b1;
    ae_d = !en ? ae_q : dump ? '0 : se;
    ap_d = !en ? ap_q : dump ? '0 : sp;
    al_d = !en ? al_q : dump ? '0 : sl;
    oe_d = dump ? se : oe_q;
    op_d = dump ? sp : op_q;
    ol_d = dump ? sl : ol_q;
    valid_d = dump | (valid_q & ~acc_ready);
    overrun_d = dump & valid_q & ~acc_ready;
    hits_n = hits_q + 1'b1;
    miss_n = miss_q + 1'b1;
    state_d = state_q;
    hits_d = hits_q;
    miss_d = miss_q;
    slip_d = 1'b0;
    // The lock FSM only steps on a dump, judging the freshly completed prompt sum.
    if (dump) begin
      if (state_q == SEARCH) begin
        if (hit) begin
          state_d = LOCK_CNT == 1 ? LOCK : VERIFY;
          hits_d = HW'(1);
          miss_d = '0;
        end else slip_d = 1'b1;
      end else if (state_q == VERIFY) begin
        if (hit) begin
          hits_d = hits_n;
          if (hits_n == HW'(LOCK_CNT)) begin
            state_d = LOCK;
            miss_d = '0;
          end
        end else begin
          state_d = SEARCH;
          hits_d = '0;
          slip_d = 1'b1;
        end
      end else begin
        miss_d = hit ? '0 : miss_n;
        if (!hit && miss_n == HW'(LOCK_CNT)) begin
          state_d = SEARCH;
          hits_d = '0;
          miss_d = '0;
          slip_d = 1'b1;
        end
      end
    end
    lock_d = state_d == LOCK;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_q <= '0;
      cnt_q <= '0;
      ae_q <= '0;
      ap_q <= '0;
      al_q <= '0;
      oe_q <= '0;
      op_q <= '0;
      ol_q <= '0;
      valid_q <= 1'b0;
      overrun_q <= 1'b0;
      slip_q <= 1'b0;
      lock_q <= 1'b0;
      state_q <= SEARCH;
      hits_q <= '0;
      miss_q <= '0;
    end else begin
      dly_q <= dly_d;
      cnt_q <= cnt_d;
      ae_q <= ae_d;
      ap_q <= ap_d;
      al_q <= al_d;
      oe_q <= oe_d;
      op_q <= op_d;
      ol_q <= ol_d;
      valid_q <= valid_d;
      overrun_q <= overrun_d;
      slip_q <= slip_d;
      lock_q <= lock_d;
      state_q <= state_d;
      hits_q <= hits_d;
      miss_q <= miss_d;
    end
  end
endmodule
